// File: rtl/gmsk_pkg.sv
// gmsk_pkg: shared GMSK modem sizing and pipeline tag type.
`default_nettype none
package gmsk_pkg;
   localparam int IQ_BITS            = 9;
   localparam int SAMPLES_PER_SYMBOL = 255;
   localparam int CNT_BITS           = 8;
   localparam int ACC_BITS           = 2*IQ_BITS + 1 + CNT_BITS;

   typedef struct packed {
      logic valid;
      logic last;
      logic first;
   } tag_t;
endpackage
`default_nettype wire

// File: rtl/gmsk_xprod_discriminator.sv
// gmsk_xprod_discriminator: cur/prev sample regs, cross products and their
// difference (S1-S3), carrying valid/last/first tags alongside the data.
`default_nettype none
module gmsk_xprod_discriminator
   import gmsk_pkg::*;
#(
   parameter int IQ_BITS = gmsk_pkg::IQ_BITS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_valid,
   input  logic                        i_last,
   input  logic                        i_first,
   input  logic signed [IQ_BITS-1:0]   i_i,
   input  logic signed [IQ_BITS-1:0]   i_q,
   output tag_t                        o_tag,
   output logic signed [2*IQ_BITS:0]   o_diff
);
   localparam int PW = 2*IQ_BITS;

   logic signed [IQ_BITS-1:0] r_cur_i, r_cur_q, r_prev_i, r_prev_q;
   logic signed [PW-1:0]      r_p1, r_p2;
   logic signed [PW:0]        r_diff;
   tag_t                      r_tag1, r_tag2, r_tag3;

   logic signed [PW-1:0] w_prev_i_x, w_prev_q_x, w_cur_i_x, w_cur_q_x;
   logic signed [PW-1:0] w_p1, w_p2;
   logic signed [PW:0]   w_diff;

   // Operands widened to the full product width so the products are exact.
   assign w_prev_i_x = $signed({{IQ_BITS{r_prev_i[IQ_BITS-1]}}, r_prev_i});
   assign w_prev_q_x = $signed({{IQ_BITS{r_prev_q[IQ_BITS-1]}}, r_prev_q});
   assign w_cur_i_x  = $signed({{IQ_BITS{r_cur_i[IQ_BITS-1]}}, r_cur_i});
   assign w_cur_q_x  = $signed({{IQ_BITS{r_cur_q[IQ_BITS-1]}}, r_cur_q});
   assign w_p1       = w_prev_i_x * w_cur_q_x;
   assign w_p2       = w_prev_q_x * w_cur_i_x;
   assign w_diff     = $signed({r_p1[PW-1], r_p1}) - $signed({r_p2[PW-1], r_p2});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur_i  <= '0;
         r_cur_q  <= '0;
         r_prev_i <= '0;
         r_prev_q <= '0;
         r_p1     <= '0;
         r_p2     <= '0;
         r_diff   <= '0;
         r_tag1   <= '0;
         r_tag2   <= '0;
         r_tag3   <= '0;
      end else begin
         r_tag1 <= '{valid: i_valid, last: i_last, first: i_first};
         r_tag2 <= r_tag1;
         r_tag3 <= r_tag2;
         if (i_valid) begin
            r_cur_i  <= i_i;
            r_cur_q  <= i_q;
            r_prev_i <= r_cur_i;
            r_prev_q <= r_cur_q;
         end
         if (r_tag1.valid) begin
            r_p1 <= w_p1;
            r_p2 <= w_p2;
         end
         if (r_tag2.valid) begin
            r_diff <= w_diff;
         end
      end
   end

   assign o_tag  = r_tag3;
   assign o_diff = r_diff;
endmodule
`default_nettype wire

// File: rtl/gmsk_demodulate.sv
// gmsk_demodulate: differential-phase GMSK demodulator with integrate-and-dump
// per symbol. Optional symbol-edge resync under GMSK_DEMOD_EDGE_SYNC_EN.
`default_nettype none
module gmsk_demodulate
   import gmsk_pkg::*;
#(
   parameter int IQ_BITS            = gmsk_pkg::IQ_BITS,
   parameter int SAMPLES_PER_SYMBOL = gmsk_pkg::SAMPLES_PER_SYMBOL,
   parameter int CNT_BITS           = gmsk_pkg::CNT_BITS,
   parameter int ACC_BITS           = 2*IQ_BITS + 1 + CNT_BITS,
   parameter bit INVERT             = 1'b0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       sample_strobe_i,
   input  logic signed [IQ_BITS-1:0]  inphase_in,
   input  logic signed [IQ_BITS-1:0]  quadrature_in,
   input  logic                       iq_symbol_edge_i,
   output logic                       symbol_o,
   output logic                       symbol_strobe_o,
   output logic signed [ACC_BITS-1:0] soft_metric_o,
   output logic                       resync_o
);
   localparam int DW = 2*IQ_BITS + 1;

   logic [CNT_BITS-1:0]        r_cnt;
   logic signed [ACC_BITS-1:0] r_acc;

   logic                       w_last, w_first;
   logic [CNT_BITS-1:0]        w_cnt_nxt;
   tag_t                       w_tag;
   logic signed [DW-1:0]       w_diff;
   logic signed [ACC_BITS-1:0] w_diff_x, w_sum;
   logic                       w_sum_pos, w_acc_pos;

   always_comb begin
      w_last    = (r_cnt == CNT_BITS'(SAMPLES_PER_SYMBOL-1));
      w_first   = 1'b0;
      w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
`ifdef GMSK_DEMOD_EDGE_SYNC_EN
      // An edge makes this sample index 0; a nonzero count means the previous
      // symbol was cut short and must be dumped when this sample reaches S4.
      if (iq_symbol_edge_i) begin
         w_last    = 1'b0;
         w_first   = (r_cnt != '0);
         w_cnt_nxt = CNT_BITS'(1);
      end
`endif
   end

`ifndef GMSK_DEMOD_EDGE_SYNC_EN
   logic w_unused_edge;
   assign w_unused_edge = iq_symbol_edge_i;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (sample_strobe_i) begin
         r_cnt <= w_cnt_nxt;
      end
   end

   gmsk_xprod_discriminator #(
      .IQ_BITS (IQ_BITS)
   ) u_xprod (
      .clk     (clock),
      .rst     (reset),
      .i_valid (sample_strobe_i),
      .i_last  (sample_strobe_i & w_last),
      .i_first (sample_strobe_i & w_first),
      .i_i     (inphase_in),
      .i_q     (quadrature_in),
      .o_tag   (w_tag),
      .o_diff  (w_diff)
   );

   assign w_diff_x  = $signed({{(ACC_BITS-DW){w_diff[DW-1]}}, w_diff});
   assign w_sum     = r_acc + w_diff_x;
   // Strictly positive decides 1; zero decides 0.
   assign w_sum_pos = !w_sum[ACC_BITS-1] && (w_sum != '0);
   assign w_acc_pos = !r_acc[ACC_BITS-1] && (r_acc != '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_acc           <= '0;
         soft_metric_o   <= '0;
         symbol_o        <= 1'b0;
         symbol_strobe_o <= 1'b0;
         resync_o        <= 1'b0;
      end else begin
         symbol_strobe_o <= 1'b0;
         resync_o        <= 1'b0;
         if (w_tag.valid) begin
            if (w_tag.first) begin
               soft_metric_o   <= r_acc;
               symbol_o        <= w_acc_pos ^ INVERT;
               symbol_strobe_o <= 1'b1;
               resync_o        <= 1'b1;
               r_acc           <= w_diff_x;
            end else if (w_tag.last) begin
               soft_metric_o   <= w_sum;
               symbol_o        <= w_sum_pos ^ INVERT;
               symbol_strobe_o <= 1'b1;
               r_acc           <= '0;
            end else begin
               r_acc <= w_sum;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_gmsk_demodulate.sv
// tb_gmsk_demodulate: directed vectors at 4 samples/symbol, scoreboard checks
// of two instances (normal and inverted polarity).
`default_nettype none
module tb_gmsk_demodulate;
   localparam int IQW = 9;
   localparam int AW  = 27;

   typedef struct {
      bit              sym;
      logic signed [AW-1:0] met;
      bit              rs;
      int              cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic strobe = 1'b0;
   logic signed [IQW-1:0] i_s = '0, q_s = '0;
   logic edge_s = 1'b0;

   logic sym0, stb0, rs0, sym1, stb1, rs1;
   logic signed [AW-1:0] met0, met1;

   exp_t q0[$];
   exp_t q1[$];
   int total = 0, bad = 0, cyc = 0, drive_cyc = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   gmsk_demodulate #(.SAMPLES_PER_SYMBOL(4), .INVERT(1'b0)) dut (
      .clock(clock), .reset(reset), .sample_strobe_i(strobe),
      .inphase_in(i_s), .quadrature_in(q_s), .iq_symbol_edge_i(edge_s),
      .symbol_o(sym0), .symbol_strobe_o(stb0), .soft_metric_o(met0), .resync_o(rs0));

   gmsk_demodulate #(.SAMPLES_PER_SYMBOL(4), .INVERT(1'b1)) dut_inv (
      .clock(clock), .reset(reset), .sample_strobe_i(strobe),
      .inphase_in(i_s), .quadrature_in(q_s), .iq_symbol_edge_i(edge_s),
      .symbol_o(sym1), .symbol_strobe_o(stb1), .soft_metric_o(met1), .resync_o(rs1));

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, req);
      end
   endtask

   // Called at a negedge; holds the sample for one clock then idles gap clocks.
   task automatic smp(input int iv, input int qv, input bit e, input int gap);
      strobe = 1'b1; i_s = IQW'(iv); q_s = IQW'(qv); edge_s = e; drive_cyc = cyc;
      @(negedge clock);
      strobe = 1'b0; edge_s = 1'b0;
      repeat (gap) @(negedge clock);
   endtask

   // Strobe appears on the 4th rising edge counting the capture edge.
   task automatic expect_sym(input bit s, input int m, input bit rs);
      q0.push_back('{sym: s,  met: AW'(m), rs: rs, cyc: drive_cyc + 4});
      q1.push_back('{sym: !s, met: AW'(m), rs: rs, cyc: drive_cyc + 4});
   endtask

   task automatic sym_ccw(input int m, input int gap);
      smp(100, 0, 0, gap); smp(0, 100, 0, gap); smp(-100, 0, 0, gap); smp(0, -100, 0, gap);
      expect_sym(1'b1, m, 1'b0);
   endtask

   task automatic sym_cw(input int m, input int gap);
      smp(100, 0, 0, gap); smp(0, -100, 0, gap); smp(-100, 0, 0, gap); smp(0, 100, 0, gap);
      expect_sym(1'b0, m, 1'b0);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (!reset && stb0) begin
         if (q0.size() == 0) chk("unexpected_strobe", 1, 0);
         else begin
            e = q0.pop_front();
            chk("symbol", sym0, e.sym);
            chk("metric", met0, e.met);
            chk("resync", rs0, e.rs);
            chk("latency_cycle", cyc, e.cyc);
         end
      end
      if (!reset && stb1) begin
         if (q1.size() == 0) chk("unexpected_strobe_inv", 1, 0);
         else begin
            e = q1.pop_front();
            chk("symbol_inv", sym1, e.sym);
            chk("metric_inv", met1, e.met);
            chk("resync_inv", rs1, e.rs);
         end
      end
      if (!reset && !stb0 && rs0) chk("resync_without_strobe", 1, 0);
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_strobe"}, stb0, 0);
      chk({tag, "_symbol"}, sym0, 0);
      chk({tag, "_metric"}, met0, 0);
      chk({tag, "_resync"}, rs0, 0);
      chk({tag, "_metric_inv"}, met1, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      chk_zero("reset");
      reset = 1'b0;
      @(negedge clock);

      // CCW, strobe every clock: first sample after reset contributes 0.
      sym_ccw(30000, 0);
      sym_ccw(40000, 0);
      sym_ccw(40000, 0);
      // CW: entry from (0,-100) to (100,0) is one +10000 step.
      sym_cw(-20000, 0);
      sym_cw(-40000, 0);
      // CCW with strobe every 3rd clock: entry from (0,100) to (100,0) is -10000.
      sym_ccw(20000, 2);
      sym_ccw(40000, 2);
      // All-zero samples: zero metric decides 0.
      repeat (4) smp(0, 0, 0, 0);
      expect_sym(1'b0, 0, 1'b0);
      // Full-scale corners.
      smp(-256, -256, 0, 0); smp(255, -256, 0, 0); smp(255, 255, 0, 0); smp(-256, 255, 0, 0);
      expect_sym(1'b1, 391426, 1'b0);
      smp(-256, -256, 0, 1); smp(255, -256, 0, 1); smp(255, 255, 0, 1); smp(-256, 255, 0, 1);
      expect_sym(1'b1, 522242, 1'b0);
      repeat (8) @(negedge clock);

      // Reset mid-symbol: partial work dropped, no strobe.
      smp(100, 0, 0, 0); smp(0, 100, 0, 0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk_zero("midreset");
      reset = 1'b0;
      repeat (6) @(negedge clock);
      chk("post_reset_quiet", stb0, 0);
      sym_ccw(30000, 0);
      sym_ccw(40000, 1);

`ifdef GMSK_DEMOD_EDGE_SYNC_EN
      // Edge on the 3rd sample: two-sample symbol dumped with resync.
      smp(100, 0, 0, 0); smp(0, 100, 0, 0);
      smp(-100, 0, 1, 0);
      expect_sym(1'b1, 20000, 1'b1);
      smp(0, -100, 0, 0); smp(100, 0, 0, 0); smp(0, 100, 0, 0);
      expect_sym(1'b1, 40000, 1'b0);
      // Edge when already aligned: ordinary symbol.
      smp(-100, 0, 1, 0); smp(0, -100, 0, 0); smp(100, 0, 0, 0); smp(0, 100, 0, 0);
      expect_sym(1'b1, 40000, 1'b0);
`else
      // Edge input ignored: stays a normal symbol.
      smp(100, 0, 0, 0); smp(0, 100, 0, 0); smp(-100, 0, 1, 0); smp(0, -100, 0, 0);
      expect_sym(1'b1, 40000, 1'b0);
`endif

      repeat (12) @(negedge clock);
      chk("queue_drained", q0.size(), 0);
      chk("queue_drained_inv", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
